// File: rtl/fpu_mul_pkg.sv
// Shared types and constants for the shared-FPU-multiplier arbiter slice.
package fpu_mul_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam fp32_t FP_ONE = 32'h3F80_0000;
  localparam fp32_t FP_TWO = 32'h4000_0000;

endpackage

// File: rtl/multi.sv
// Combinational FP32 multiplier: round-to-nearest-even, subnormals flushed to zero.
module multi (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] op
);

  logic        sign;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0] prod;
  logic [24:0] rmant;
  logic [22:0] frac;
  logic        guard, sticky;
  logic [9:0]  esum;
  logic [9:0]  eout;

  always_comb begin
    sign   = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    prod   = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    esum   = {2'b00, a[30:23]} + {2'b00, b[30:23]};

    // Normalise the 48-bit product to a 24-bit significand plus guard/sticky.
    if (prod[47]) begin
      rmant  = {1'b0, prod[47:24]};
      guard  = prod[23];
      sticky = |prod[22:0];
      esum   = esum + 10'd1;
    end else begin
      rmant  = {1'b0, prod[46:23]};
      guard  = prod[22];
      sticky = |prod[21:0];
    end

    if (guard && (sticky || rmant[0])) begin
      rmant = rmant + 25'd1;
    end

    if (rmant[24]) begin
      frac = rmant[23:1];
      esum = esum + 10'd1;
    end else begin
      frac = rmant[22:0];
    end

    eout = esum - 10'd127;

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      op = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      op = {sign, 8'hFF, 23'h0};
    end else if (a_zero || b_zero || (esum <= 10'd127)) begin
      op = {sign, 31'h0};
    end else if ((eout[9:8] != 2'b00) || (eout[7:0] == 8'hFF)) begin
      op = {sign, 8'hFF, 23'h0};
    end else begin
      op = {sign, eout[7:0], frac};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gidx
);

  always_comb begin
    logic        found;
    int unsigned idx;
    found = 1'b0;
    grant = '0;
    gidx  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Round-robin sequencer sharing one combinational FP32 multiplier among NREQ lanes,
// returning each product with its requester ID on a valid/ready port.
module fpu_mul_arbiter
  import fpu_mul_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned IDW     = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]  req_ready,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic [IDW-1:0]   rsp_id,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  grant_id;
  logic [CW-1:0]   cnt;
  fp32_t           op_a, op_b;
  fp32_t           mul_op;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  fp32_t           a_arr [NREQ];
  fp32_t           b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[32*i +: 32];
    assign b_arr[i] = req_b[32*i +: 32];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .gidx  (gidx)
  );

  multi u_multi (
    .a  (op_a),
    .b  (op_b),
    .op (mul_op)
  );

  // Grants are only offered while idle; any set grant bit is a handshake.
  assign req_ready = (state == IDLE) ? grant : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|grant) begin
            op_a     <= a_arr[gidx];
            op_b     <= b_arr[gidx];
            grant_id <= gidx;
            cnt      <= CW'(MUL_LAT - 1);
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_data  <= mul_op;
            rsp_id    <= grant_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter: table of single transactions plus
// round-robin, backpressure, operand-stability and mid-operation reset sequences.
module tb_fpu_mul_arbiter;
  import fpu_mul_pkg::*;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned IDW     = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic [31:0]        rsp_data;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_ready;
  logic               busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    slot;
    fp32_t a;
    fp32_t b;
    fp32_t p;
  } vec_t;

  vec_t vecs [7];

  fpu_mul_arbiter #(
    .NREQ    (NREQ),
    .MUL_LAT (MUL_LAT),
    .IDW     (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic set_slot(input int slot, input fp32_t a, input fp32_t b);
    req_valid[slot]        = 1'b1;
    req_a[32*slot +: 32]   = a;
    req_b[32*slot +: 32]   = b;
  endtask

  // Entered at negedge+1 of handshake cycle T; returns at negedge+1 of T+4.
  task automatic expect_txn(input logic [NREQ-1:0] g, input int id, input fp32_t p);
    chk("grant", 32'(req_ready), 32'(g));
    chk("busy_T", 32'(busy), 32'd0);
    @(negedge clk); #1;
    chk("busy_T1", 32'(busy), 32'd1);
    chk("rsp_valid_T1", 32'(rsp_valid), 32'd0);
    chk("ready_T1", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    chk("busy_T2", 32'(busy), 32'd1);
    chk("rsp_valid_T2", 32'(rsp_valid), 32'd0);
    @(negedge clk); #1;
    chk("rsp_valid_T3", 32'(rsp_valid), 32'd1);
    chk("rsp_data", rsp_data, p);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("busy_T3", 32'(busy), 32'd1);
    @(negedge clk); #1;
    chk("rsp_valid_T4", 32'(rsp_valid), 32'd0);
    chk("busy_T4", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000};  // 2*3=6
    vecs[1] = '{2, 32'hBF80_0000, 32'h4080_0000, 32'hC080_0000};  // -1*4=-4
    vecs[2] = '{1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000};  // 1.5*1.5=2.25
    vecs[3] = '{3, FP_ONE,        FP_TWO,        32'h4000_0000};  // 1*2=2
    vecs[4] = '{1, 32'h0000_0000, 32'h4040_0000, 32'h0000_0000};  // 0*3=0
    vecs[5] = '{0, 32'h7F80_0000, FP_ONE,        32'h7F80_0000};  // inf*1=inf
    vecs[6] = '{2, 32'h4020_0000, 32'h4080_0000, 32'h4120_0000};  // 2.5*4=10

    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    clear_req();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesting from reset: strict 0,1,2,3 order, 4-cycle interval.
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_slot(i, 32'h3FC0_0000, 32'h3FC0_0000);
    #1;
    for (int k = 0; k < NREQ; k++) begin
      expect_txn(NREQ'(1 << k), k, 32'h4010_0000);
    end
    clear_req();

    // Table of single isolated transactions.
    for (int i = 0; i < 7; i++) begin
      set_slot(vecs[i].slot, vecs[i].a, vecs[i].b);
      #1;
      expect_txn(NREQ'(1 << vecs[i].slot), vecs[i].slot, vecs[i].p);
      clear_req();
    end

    // Serve slot 2 (rr_ptr -> 3), then slots 0 and 3 contend: 3 wins, then 0.
    set_slot(2, FP_TWO, FP_TWO);
    #1;
    expect_txn(4'b0100, 2, 32'h4080_0000);
    clear_req();
    set_slot(0, FP_ONE, FP_ONE);
    set_slot(3, FP_TWO, 32'h4040_0000);
    #1;
    expect_txn(4'b1000, 3, 32'h40C0_0000);
    expect_txn(4'b0001, 0, FP_ONE);
    clear_req();

    // Backpressure on slot 2: response held, no grants while others request.
    set_slot(2, 32'hBF80_0000, 32'h4080_0000);
    #1;
    chk("bp_grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    clear_req();
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", rsp_data, 32'hC080_0000);
      chk("bp_rsp_id", 32'(rsp_id), 32'd2);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    clear_req();
    #1;
    chk("bp_still_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk); #1;
    chk("bp_accepted", 32'(rsp_valid), 32'd0);
    chk("bp_idle", 32'(busy), 32'd0);

    // Operand stability: granted slot's operands change during EXEC.
    set_slot(1, 32'h4000_0000, 32'h4040_0000);
    #1;
    chk("stab_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_a[63:32] = 32'h0;
    req_b[63:32] = 32'h0;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    chk("stab_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stab_rsp_data", rsp_data, 32'h40C0_0000);
    chk("stab_rsp_id", 32'(rsp_id), 32'd1);
    @(negedge clk);
    clear_req();

    // Reset during EXEC (rr_ptr is 2 beforehand): abandons the op, ptr back to 0.
    set_slot(3, FP_TWO, FP_TWO);
    #1;
    chk("rstx_grant", 32'(req_ready), 32'b1000);
    @(negedge clk); #1;
    chk("rstx_busy", 32'(busy), 32'd1);
    clear_req();
    rst_n = 1'b0;
    #1;
    chk("rstx_busy0", 32'(busy), 32'd0);
    chk("rstx_rsp_valid0", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk("rstx_no_rsp", 32'(rsp_valid), 32'd0);
    end
    set_slot(1, FP_ONE, FP_TWO);
    set_slot(3, FP_TWO, FP_TWO);
    #1;
    expect_txn(4'b0010, 1, FP_TWO);
    clear_req();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
